// File: rtl/l2_mem_pkg.sv
// ============================================================================
// l2_mem_pkg : shared types and defaults for the L2 main-memory burst arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package l2_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_DATA_WIDTH   = 64;
    localparam int unsigned DEF_BURST_LENGTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_FILL = 1'b0,
        REQ_WB   = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/l2_rr_arb2.sv
// ============================================================================
// l2_rr_arb2 : two-input round-robin picker (fill vs write-back)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module l2_rr_arb2
    import l2_mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_fill,
    input  logic i_req_wb,
    input  logic i_upd,
    input  logic i_upd_wb,
    output logic o_valid,
    output logic o_pick_wb
);

    req_id_t r_last;

    // Reset value REQ_FILL makes write-back win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_FILL;
        end else if (i_upd) begin
            r_last <= i_upd_wb ? REQ_WB : REQ_FILL;
        end
    end

    assign o_valid   = i_en & (i_req_fill | i_req_wb);
    assign o_pick_wb = i_req_wb & (~i_req_fill | (r_last == REQ_FILL));

endmodule

`default_nettype wire

// File: rtl/l2_mem_burst_arbiter.sv
// ============================================================================
// l2_mem_burst_arbiter : shares the main-memory bus between L2 fill reads and
//                        write-back bursts, sequencing toggle-strobed beats
// Revision             : 1.0
// ============================================================================
`default_nettype none

module l2_mem_burst_arbiter
    import l2_mem_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int BURST_LENGTH     = DEF_BURST_LENGTH,
    parameter int BEAT_WIDTH       = $clog2(BURST_LENGTH),
    parameter int LINE_OFFSET_BITS = $clog2(BURST_LENGTH * DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  fill_gnt,
    output logic                  fill_valid,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic [BEAT_WIDTH-1:0] fill_beat,
    output logic                  fill_done,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_gnt,
    output logic [BEAT_WIDTH-1:0] wb_beat,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_done,
    output logic                  mem_addrstb,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_stb,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [ADDR_WIDTH-1:0] c_line_mask = {ADDR_WIDTH{1'b1}} << LINE_OFFSET_BITS;
    localparam logic [BEAT_WIDTH-1:0] c_last_beat = BEAT_WIDTH'(BURST_LENGTH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_stb_q;
    logic                    w_toggle;
    logic [BEAT_WIDTH-1:0]   r_cnt;
    logic                    w_last_beat;
    logic                    w_arb_valid;
    logic                    w_pick_wb;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic                    r_we;
    logic                    r_oe;
    logic                    r_addrstb;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_fill_valid;
    logic [DATA_WIDTH-1:0]   r_fill_data;
    logic [BEAT_WIDTH-1:0]   r_fill_beat;
    logic                    r_proto_err;

    assign w_toggle    = mem_stb ^ r_stb_q;
    assign w_last_beat = (r_cnt == c_last_beat);
    assign w_req_addr  = w_pick_wb ? wb_addr : fill_addr;

    l2_rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_state == ST_IDLE),
        .i_req_fill (fill_req),
        .i_req_wb   (wb_req),
        .i_upd      (r_state == ST_DONE),
        .i_upd_wb   (~r_we),
        .o_valid    (w_arb_valid),
        .o_pick_wb  (w_pick_wb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fill_gnt    = 1'b0;
        wb_gnt      = 1'b0;
        fill_done   = 1'b0;
        wb_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                fill_gnt    = r_we;
                wb_gnt      = ~r_we;
                w_state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (w_toggle && w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                fill_done   = r_we;
                wb_done     = ~r_we;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_q      <= 1'b0;
            r_cnt        <= '0;
            r_we         <= 1'b1;
            r_oe         <= 1'b0;
            r_addrstb    <= 1'b0;
            r_addr       <= '0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_fill_beat  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_stb_q      <= mem_stb;
            r_fill_valid <= 1'b0;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_addr <= w_req_addr & c_line_mask;
                r_we   <= ~w_pick_wb;
                r_oe   <= w_pick_wb;
                r_cnt  <= '0;
            end
            if (r_state == ST_ADDR) begin
                r_addrstb <= ~r_addrstb;
            end
            // The final beat holds the counter; it restarts only at the next grant.
            if (r_state == ST_BURST && w_toggle) begin
                if (r_we) begin
                    r_fill_valid <= 1'b1;
                    r_fill_data  <= mem_rdata;
                    r_fill_beat  <= r_cnt;
                end
                if (w_last_beat) begin
                    r_oe <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + BEAT_WIDTH'(1);
                end
            end
            if (r_state != ST_BURST && w_toggle) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign fill_valid  = r_fill_valid;
    assign fill_data   = r_fill_data;
    assign fill_beat   = r_fill_beat;
    assign wb_beat     = r_cnt;
    assign mem_addrstb = r_addrstb;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_oe      = r_oe;
    assign mem_wdata   = r_oe ? wb_data : '0;
    assign busy        = (r_state != ST_IDLE);
    assign proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_burst_arbiter.sv
// ============================================================================
// tb_l2_mem_burst_arbiter : directed bench with toggle-strobe memory responder
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_l2_mem_burst_arbiter;

    localparam int BL = 8;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 3;
    localparam logic [AW-1:0] LINE_MASK = ~32'(BL * DW / 8 - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fill_req = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic          fill_gnt, fill_valid, fill_done;
    logic [DW-1:0] fill_data;
    logic [BW-1:0] fill_beat;
    logic          wb_req = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic          wb_gnt, wb_done;
    logic [BW-1:0] wb_beat;
    logic [DW-1:0] wb_data;
    logic          mem_addrstb, mem_we, mem_oe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_stb;
    logic          busy, proto_err;

    l2_mem_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_gnt(fill_gnt),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_beat(fill_beat),
        .fill_done(fill_done),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_gnt(wb_gnt), .wb_beat(wb_beat),
        .wb_data(wb_data), .wb_done(wb_done),
        .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_stb(mem_stb), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Write-back source: data is a pure function of the requested beat.
    assign wb_data = 64'(wb_beat) * 64'h11;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int            m_period = 1;
    int            inj_req = 0;
    int            inj_ack = 0;
    logic [63:0]   cap [0:BL-1];
    logic          m_active, m_prev_astb, m_we_l;
    int            m_beat, m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_stb     <= 1'b0;
            mem_rdata   <= '0;
            m_active    <= 1'b0;
            m_prev_astb <= 1'b0;
            m_we_l      <= 1'b1;
            m_beat      <= 0;
            m_wait      <= 0;
        end else if (inj_req != inj_ack) begin
            inj_ack <= inj_req;
            mem_stb <= ~mem_stb;
        end else if (m_active) begin
            if (m_wait == 0) begin
                mem_stb <= ~mem_stb;
                if (m_we_l) mem_rdata <= 64'hA0 + 64'(m_beat);
                else        cap[m_beat] <= mem_wdata;
                m_beat <= m_beat + 1;
                m_wait <= m_period - 1;
                if (m_beat == BL - 1) m_active <= 1'b0;
            end else begin
                m_wait <= m_wait - 1;
            end
        end else if (mem_addrstb != m_prev_astb) begin
            m_prev_astb <= mem_addrstb;
            m_active    <= 1'b1;
            m_beat      <= 0;
            m_wait      <= 0;
            m_we_l      <= mem_we;
        end
    end

    // ---------------- reference model ----------------
    int            m_owner;          // 0 none, 1 fill, 2 write-back
    logic          m_granted, m_in_done, m_last_wb, m_stbq;
    logic [BW-1:0] m_cnt;
    logic          e_gnt_f, e_gnt_w, e_valid, e_done_f, e_done_w, e_oe, e_we, e_astb, e_err;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_beat;
    logic [AW-1:0] e_addr;
    logic          tb_tog, tb_pick_wb;

    assign tb_tog     = mem_stb ^ m_stbq;
    assign tb_pick_wb = wb_req && (!fill_req || !m_last_wb);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0; m_granted <= 1'b0; m_in_done <= 1'b0; m_last_wb <= 1'b0;
            m_stbq <= 1'b0; m_cnt <= '0;
            e_gnt_f <= 1'b0; e_gnt_w <= 1'b0; e_valid <= 1'b0; e_done_f <= 1'b0;
            e_done_w <= 1'b0; e_oe <= 1'b0; e_we <= 1'b1; e_astb <= 1'b0; e_err <= 1'b0;
            e_data <= '0; e_beat <= '0; e_addr <= '0;
        end else begin
            m_stbq   <= mem_stb;
            e_gnt_f  <= 1'b0;
            e_gnt_w  <= 1'b0;
            e_valid  <= 1'b0;
            e_done_f <= 1'b0;
            e_done_w <= 1'b0;
            if (m_in_done) begin
                m_in_done <= 1'b0;
                m_owner   <= 0;
                if (tb_tog) e_err <= 1'b1;
            end else if (m_owner == 0) begin
                if (tb_tog) e_err <= 1'b1;
                if (fill_req || wb_req) begin
                    m_owner   <= tb_pick_wb ? 2 : 1;
                    m_granted <= 1'b1;
                    m_cnt     <= '0;
                    e_gnt_w   <= tb_pick_wb;
                    e_gnt_f   <= !tb_pick_wb;
                    e_addr    <= (tb_pick_wb ? wb_addr : fill_addr) & LINE_MASK;
                    e_we      <= !tb_pick_wb;
                    e_oe      <= tb_pick_wb;
                end
            end else if (m_granted) begin
                m_granted <= 1'b0;
                e_astb    <= ~e_astb;
                if (tb_tog) e_err <= 1'b1;
            end else if (tb_tog) begin
                if (m_owner == 1) begin
                    e_valid <= 1'b1;
                    e_data  <= mem_rdata;
                    e_beat  <= m_cnt;
                end
                if (m_cnt == BW'(BL - 1)) begin
                    m_in_done <= 1'b1;
                    e_oe      <= 1'b0;
                    m_last_wb <= (m_owner == 2);
                    e_done_f  <= (m_owner == 1);
                    e_done_w  <= (m_owner == 2);
                end else begin
                    m_cnt <= m_cnt + BW'(1);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fill_gnt", 64'(fill_gnt), 64'(e_gnt_f));
        chk("wb_gnt", 64'(wb_gnt), 64'(e_gnt_w));
        chk("fill_valid", 64'(fill_valid), 64'(e_valid));
        chk("fill_done", 64'(fill_done), 64'(e_done_f));
        chk("wb_done", 64'(wb_done), 64'(e_done_w));
        chk("busy", 64'(busy), 64'(m_owner != 0));
        chk("mem_oe", 64'(mem_oe), 64'(e_oe));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_addrstb", 64'(mem_addrstb), 64'(e_astb));
        chk("proto_err", 64'(proto_err), 64'(e_err));
        if (e_valid) begin
            chk("fill_data", fill_data, e_data);
            chk("fill_beat", 64'(fill_beat), 64'(e_beat));
        end
        if (m_owner == 2) chk("wb_beat", 64'(wb_beat), 64'(m_cnt));
        if (e_oe) chk("mem_wdata", mem_wdata, 64'(m_cnt) * 64'h11);
    end

    // ---------------- observation queues ----------------
    int          vbeat [$];
    logic [63:0] vdata [$];
    int          gq [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (fill_valid) begin
                vbeat.push_back(int'(fill_beat));
                vdata.push_back(fill_data);
            end
            if (fill_gnt) gq.push_back(1);
            if (wb_gnt)   gq.push_back(2);
        end
    end

    task automatic run(input int budget, input int drop_beat, output int first_done, output int oe_cnt);
        int cyc;
        cyc = 0;
        first_done = 0;
        oe_cnt = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (mem_oe) oe_cnt++;
            if ((fill_done || wb_done) && first_done == 0) first_done = cyc;
            if (drop_beat >= 0 && fill_valid && fill_beat == BW'(drop_beat)) fill_req = 1'b0;
            if (fill_done) fill_req = 1'b0;
            if (wb_done)   wb_req = 1'b0;
            if (!fill_req && !wb_req && !busy) break;
            if (cyc >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: still busy after %0d cycles, required idle", cyc);
                fill_req = 1'b0;
                wb_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_beats(input string name, input int base);
        chk({name, "_count"}, 64'(vbeat.size() - base), 64'(BL));
        for (int i = 0; i < BL && base + i < vbeat.size(); i++) begin
            chk({name, "_beat"}, 64'(vbeat[base + i]), 64'(i));
            chk({name, "_data"}, vdata[base + i], 64'hA0 + 64'(i));
        end
    endtask

    initial begin
        int fd, oc, base, gbase, cyc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_mem_we", 64'(mem_we), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_fill_data", fill_data, 64'd0);
        chk("rst_addrstb", 64'(mem_addrstb), 64'd0);

        // Read burst, memory toggling every cycle
        fill_addr = 32'h0000_1234;
        fill_req = 1'b1;
        base = vbeat.size();
        run(60, -1, fd, oc);
        chk("fill_done_latency", 64'(fd), 64'd12);
        chk("fill_line_addr", 64'(mem_addr), 64'h0000_1200);
        chk("fill_we", 64'(mem_we), 64'd1);
        chk_beats("fill", base);

        // Write-back burst, memory toggling every third cycle
        m_period = 3;
        wb_addr = 32'h0000_8ABC;
        wb_req = 1'b1;
        run(100, -1, fd, oc);
        for (int i = 0; i < BL; i++) chk("wb_capture", cap[i], 64'(i) * 64'h11);
        chk("wb_we", 64'(mem_we), 64'd0);
        chk("wb_line_addr", 64'(mem_addr), 64'h0000_8A80);
        chk("wb_oe_cycles", 64'(oc), 64'd25);
        m_period = 1;

        // Simultaneous requests after reset, twice
        do_reset();
        gbase = gq.size();
        fill_req = 1'b1;
        wb_req = 1'b1;
        run(100, -1, fd, oc);
        fill_req = 1'b1;
        wb_req = 1'b1;
        run(100, -1, fd, oc);
        chk("grant_count", 64'(gq.size() - gbase), 64'd4);
        for (int i = 0; i < 4 && gbase + i < gq.size(); i++)
            chk("grant_order", 64'(gq[gbase + i]), (i % 2 == 0) ? 64'd2 : 64'd1);

        // Stray strobe toggle while idle
        base = vbeat.size();
        inj_req = inj_req + 1;
        repeat (4) @(negedge clk);
        chk("idle_toggle_err", 64'(proto_err), 64'd1);
        chk("idle_toggle_nobeat", 64'(vbeat.size() - base), 64'd0);
        fill_req = 1'b1;
        run(60, -1, fd, oc);
        chk("err_sticky", 64'(proto_err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(proto_err), 64'd0);

        // Reset in the middle of a read at beat 3
        fill_addr = 32'h0000_2040;
        fill_req = 1'b1;
        cyc = 0;
        while (!(fill_valid && fill_beat == 3'd3) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("beat3_reached", 64'(cyc < 60), 64'd1);
        #2 rst_n = 1'b0;
        fill_req = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(fill_valid), 64'd0);
        chk("mid_rst_data", fill_data, 64'd0);
        chk("mid_rst_we", 64'(mem_we), 64'd1);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_oe", 64'(mem_oe), 64'd0);
        chk("mid_rst_addrstb", 64'(mem_addrstb), 64'd0);
        chk("mid_rst_wb_beat", 64'(wb_beat), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        base = vbeat.size();
        fill_req = 1'b1;
        run(60, -1, fd, oc);
        chk_beats("after_rst", base);

        // Request dropped at beat 2 still completes
        base = vbeat.size();
        fill_req = 1'b1;
        run(60, 2, fd, oc);
        chk("drop_done_seen", 64'(fd != 0), 64'd1);
        chk_beats("drop", base);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
